// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, types.
// Optional feature macro: MDU_MADD_EN (enables op 7 = MADD).
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_MADD  = 3'd7;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MDU_CNT_W           = 8;

  typedef logic [63:0]          mdu_res_t;
  typedef logic [MDU_CNT_W-1:0] mdu_cnt_t;

  typedef enum logic {
    MDU_IDLE,
    MDU_RUN
  } mdu_state_e;

  // True for ops that occupy the unit for multiple cycles.
  function automatic logic mdu_is_multi(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD});
`else
    return (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU});
`endif
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath; one shared multiplier and one shared divider.
// Optional feature macro: MDU_MADD_EN (op 7 accumulates the signed product into HI/LO).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        mul_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  mdu_res_t    prod;

  logic        div_sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quot;
  logic [31:0] rem;
  mdu_res_t    res;

  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // unsigned product the correct signed product as well.
  assign mul_sgn = (op != MDU_MULTU);
  assign mul_a   = {{32{a[31] & mul_sgn}}, a};
  assign mul_b   = {{32{b[31] & mul_sgn}}, b};
  assign prod    = mul_a * mul_b;

  // Signed division runs on magnitudes; signs are re-applied afterwards.
  assign div_sgn = (op == MDU_DIV);
  assign a_mag   = a[31] ? (~a + 32'd1) : a;
  assign b_mag   = b[31] ? (~b + 32'd1) : b;
  assign dvd     = div_sgn ? a_mag : a;
  assign dvs     = (b == '0) ? 32'd1 : (div_sgn ? b_mag : b);
  assign quot    = dvd / dvs;
  assign rem     = dvd % dvs;

  always_comb begin
    res      = {hi, lo};
    div_zero = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU: res = prod;
      MDU_DIV: begin
        res[31:0]  = (a[31] ^ b[31]) ? (~quot + 32'd1) : quot;
        res[63:32] = a[31] ? (~rem + 32'd1) : rem;
        div_zero   = (b == '0);
      end
      MDU_DIVU: begin
        res      = {rem, quot};
        div_zero = (b == '0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD: res = {hi, lo} + prod;
`endif
      default: ;
    endcase
  end

  assign res_hi = res[63:32];
  assign res_lo = res[31:0];

endmodule

// File: rtl/mdu_core.sv
// MIPS multiply/divide unit: owns HI/LO, models latency with a busy counter.
// Optional feature macro: MDU_MADD_EN (op 7 = MADD, multi-cycle like MULT).
module mdu_core
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        pending,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state, state_d;
  mdu_cnt_t    cnt, cnt_d;
  mdu_res_t    shadow, shadow_d;
  logic        shadow_dz, shadow_dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_dz;

  mdu_calc u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi_q),
    .lo       (lo_q),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MDU_IDLE;
      cnt       <= '0;
      shadow    <= '0;
      shadow_dz <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shadow    <= shadow_d;
      shadow_dz <= shadow_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shadow_d    = shadow;
    shadow_dz_d = shadow_dz;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU
`ifdef MDU_MADD_EN
            , MDU_MADD
`endif
            : begin
              shadow_d    = {calc_hi, calc_lo};
              shadow_dz_d = 1'b0;
              cnt_d       = mdu_cnt_t'(MULT_CYCLES);
              state_d     = MDU_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              shadow_d    = {calc_hi, calc_lo};
              shadow_dz_d = calc_dz;
              cnt_d       = mdu_cnt_t'(DIV_CYCLES);
              state_d     = MDU_RUN;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        cnt_d = cnt - mdu_cnt_t'(1);
        // Commit on the edge that retires the last busy cycle; div-by-zero leaves HI/LO alone.
        if (cnt == mdu_cnt_t'(1)) begin
          state_d = MDU_IDLE;
          if (!shadow_dz) begin
            hi_d = shadow[63:32];
            lo_d = shadow[31:0];
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign busy    = (state == MDU_RUN);
  assign pending = busy | (start & mdu_is_multi(op));
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: directed literal cases plus randomized traffic
// compared every cycle against a plain-arithmetic HI/LO model.
module tb_mdu_core;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        pending;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  mdu_core #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .pending (pending),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return 64'(sx * sy);
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy;
    ux = x;
    uy = y;
    return ux * uy;
  endfunction

  function automatic logic [63:0] sdiv(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    q = 64'(sx / sy);
    r = 64'(sx % sy);
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] x, input logic [31:0] y);
    return {x % y, x / y};
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_dz;
  int          m_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_res <= '0; m_dz <= 1'b0; m_left <= 0;
    end else if (m_left != 0) begin
      if (m_left == 1 && !m_dz) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
      m_left <= m_left - 1;
    end else if (start) begin
      case (op)
        3'd1: begin m_res <= smul(a, b); m_dz <= 1'b0; m_left <= MULT_N; end
        3'd2: begin m_res <= umul(a, b); m_dz <= 1'b0; m_left <= MULT_N; end
        3'd3: begin
          m_dz <= (b == 0); m_left <= DIV_N;
          if (b != 0) m_res <= sdiv(a, b);
        end
        3'd4: begin
          m_dz <= (b == 0); m_left <= DIV_N;
          if (b != 0) m_res <= udiv(a, b);
        end
        3'd5: m_hi <= a;
        3'd6: m_lo <= a;
`ifdef MDU_MADD_EN
        3'd7: begin m_res <= {m_hi, m_lo} + smul(a, b); m_dz <= 1'b0; m_left <= MULT_N; end
`endif
        default: ;
      endcase
    end
  end

  function automatic logic model_pending();
`ifdef MDU_MADD_EN
    return (m_left != 0) || (start && ((op >= 3'd1 && op <= 3'd4) || op == 3'd7));
`else
    return (m_left != 0) || (start && op >= 3'd1 && op <= 3'd4);
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_left != 0));
      check("cyc_pending", 64'(pending), 64'(model_pending()));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'($urandom_range(1, 9));
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    tick();

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_lat", 64'(n), 64'd5);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_hi", 64'(hi), 64'h0000_0002);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_lat", 64'(n), 64'd10);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    issue(3'd4, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);

    issue(3'd5, 32'h11, 32'd0);
    check("mthi", 64'(hi), 64'h11);
    issue(3'd6, 32'h22, 32'd0);
    check("mtlo", 64'(lo), 64'h22);
    issue(3'd3, 32'd55, 32'd0);
    wait_idle(n);
    check("dz_lat", 64'(n), 64'd10);
    check("dz_hi", 64'(hi), 64'h11);
    check("dz_lo", 64'(lo), 64'h22);

    issue(3'd3, 32'd100, 32'd3);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    issue(3'd6, 32'h1234, 32'd0);
    check("mtlo_after_rst", 64'(lo), 64'h1234);

    // Start during busy must be ignored without moving the commit edge.
    issue(3'd4, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 40) begin
      if (n == 3) begin
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
        #1;
        check("busy_pending", 64'(pending), 64'd1);
      end else begin
        start = 1'b0;
      end
      n++;
      tick();
    end
    start = 1'b0;
    check("ign_lat", 64'(n), 64'd10);
    check("ign_lo", 64'(lo), 64'd14);
    check("ign_hi", 64'(hi), 64'd2);

`ifdef MDU_MADD_EN
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
    wait_idle(n);
    check("madd_lat", 64'(n), 64'd5);
    check("madd_hi", 64'(hi), 64'd1);
    check("madd_lo", 64'(lo), 64'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = rand_opnd();
      b     = rand_opnd();
      tick();
    end
    start = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
